// File: rtl/posit_extract_stream_es2_pkg.sv
// rtl/posit_extract_stream_es2_pkg.sv - shared widths, constants and value type for the ES=2 posit decoder
package posit_extract_stream_es2_pkg;

    localparam int NBITS   = 32;
    localparam int ES      = 2;
    localparam int SCALE_W = 8;
    localparam int FRAC_W  = 28;
    localparam int POSIT_SERIALIZED_WIDTH_ES2 = 39;

    localparam logic [NBITS-1:0] NAR = 32'h8000_0000;

    typedef struct packed {
        logic               sgn;
        logic [SCALE_W-1:0] scale;
        logic [FRAC_W-1:0]  fraction;
        logic               inf;
        logic               zero;
    } value_es2_t;

endpackage

// File: rtl/posit_extract_stream_es2_if.sv
// rtl/posit_extract_stream_es2_if.sv - input/output valid-ready streams of the posit decoder
interface posit_extract_stream_es2_if;
    import posit_extract_stream_es2_pkg::*;

    logic [NBITS-1:0]                      in_data;
    logic                                  in_valid;
    logic                                  in_ready;
    logic [POSIT_SERIALIZED_WIDTH_ES2-1:0] out_data;
    logic                                  out_valid;
    logic                                  out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/posit_extract_stream_es2_regime_count.sv
// rtl/posit_extract_stream_es2_regime_count.sv - leading-run length and remainder of a 31-bit posit body
module posit_regime_count (
    input  logic [30:0] bits,
    output logic [4:0]  k,
    output logic [30:0] rem
);
    logic done;

    always_comb begin
        k    = 5'd1;
        done = 1'b0;
        for (int i = 29; i >= 0; i--) begin
            if (!done && (bits[i] == bits[30])) begin
                k = k + 5'd1;
            end else begin
                done = 1'b1;
            end
        end
        // Shift of 32 (k=31) clears the word: no terminator bit exists then.
        rem = bits << ({1'b0, k} + 6'd1);
    end
endmodule

// File: rtl/posit_extract_stream_es2.sv
// rtl/posit_extract_stream_es2.sv - three-stage posit(32,2) to serialized value decoder with backpressure
module posit_extract_stream_es2
    import posit_extract_stream_es2_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    posit_extract_stream_es2_if.slave  bus
);
    logic        rdy_q;
    logic        s1_valid, s2_valid, s3_valid;
    logic        s1_adv, s2_adv, s3_adv;
    logic        in_fire;

    logic        p_zero, p_inf, p_sgn;
    logic [30:0] p_abs;

    logic        s1_sgn, s1_inf, s1_zero;
    logic [30:0] s1_a;

    logic [4:0]  rc_k;
    logic [30:0] rc_rem;
    logic [5:0]  rc_regime;

    logic        s2_sgn, s2_inf, s2_zero;
    logic [5:0]  s2_regime;
    logic [28:0] s2_rem;

    value_es2_t  v3, s3_data;

    assign s3_adv = ~s3_valid | bus.out_ready;
    assign s2_adv = ~s2_valid | s3_adv;
    assign s1_adv = ~s1_valid | s2_adv;

    // rdy_q holds in_ready low until the first edge after reset releases.
    assign bus.in_ready = rdy_q & s1_adv;
    assign in_fire      = bus.in_valid & bus.in_ready;

    assign p_zero = (bus.in_data == '0);
    assign p_inf  = (bus.in_data == NAR);
    assign p_sgn  = bus.in_data[31] & ~p_inf & ~p_zero;
    assign p_abs  = p_sgn ? (31'd0 - bus.in_data[30:0]) : bus.in_data[30:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q    <= 1'b0;
            s1_valid <= 1'b0;
            s1_sgn   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_zero  <= 1'b0;
            s1_a     <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (s1_adv) begin
                s1_valid <= in_fire;
                s1_sgn   <= p_sgn;
                s1_inf   <= p_inf;
                s1_zero  <= p_zero;
                s1_a     <= p_abs;
            end
        end
    end

    posit_regime_count u_regime_count (
        .bits (s1_a),
        .k    (rc_k),
        .rem  (rc_rem)
    );

    assign rc_regime = s1_a[30] ? ({1'b0, rc_k} - 6'd1) : (6'd0 - {1'b0, rc_k});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_sgn    <= 1'b0;
            s2_inf    <= 1'b0;
            s2_zero   <= 1'b0;
            s2_regime <= '0;
            s2_rem    <= '0;
        end else if (s2_adv) begin
            s2_valid  <= s1_valid;
            s2_sgn    <= s1_sgn;
            s2_inf    <= s1_inf;
            s2_zero   <= s1_zero;
            s2_regime <= rc_regime;
            s2_rem    <= rc_rem[30:2];
        end
    end

    // regime*4 + exp is exactly the concatenation of the signed regime and the 2 exponent bits.
    always_comb begin
        v3 = '0;
        if (s2_inf || s2_zero) begin
            v3.inf  = s2_inf;
            v3.zero = s2_zero;
        end else begin
            v3.sgn      = s2_sgn;
            v3.scale    = {s2_regime, s2_rem[28:27]};
            v3.fraction = {1'b1, s2_rem[26:0]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_valid <= 1'b0;
            s3_data  <= '0;
        end else if (s3_adv) begin
            s3_valid <= s2_valid;
            s3_data  <= v3;
        end
    end

    assign bus.out_valid = s3_valid;
    assign bus.out_data  = s3_data;
endmodule

// File: tb/tb_posit_extract_stream_es2.sv
// tb/tb_posit_extract_stream_es2.sv - scoreboard bench for the ES=2 posit decoder
module tb_posit_extract_stream_es2;
    logic clk;
    logic reset;

    posit_extract_stream_es2_if bus ();

    posit_extract_stream_es2 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    localparam logic [27:0] F1 = 28'h800_0000;

    int checks = 0;
    int passed = 0;
    int pops   = 0;
    logic [38:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [38:0] val(input logic s, input logic [7:0] sc, input logic [27:0] fr);
        return {s, sc, fr, 2'b00};
    endfunction

    task automatic check(input string name, input logic [38:0] act, input logic [38:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Monitor: a transfer happens at the next rising edge when valid&ready at the falling edge.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", bus.out_data, 39'h7f_ffff_ffff);
            end else begin
                check("out_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] p, input logic [38:0] e);
        int n;
        bus.in_data  = p;
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("send_timeout", 39'd0, 39'd1);
        else exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check(name, 39'(exp_q.size()), 39'd0);
    endtask

    logic [31:0] bp_in [5];
    logic [38:0] bp_exp[5];

    initial begin
        int n, idx, pops0;
        logic [38:0] held;

        reset         = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("reset_out_valid", 39'(bus.out_valid), 39'd0);
        check("reset_out_data", bus.out_data, 39'd0);
        check("reset_in_ready", 39'(bus.in_ready), 39'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", 39'(bus.in_ready), 39'd1);

        // single item and its latency
        send(32'h4000_0000, val(1'b0, 8'h00, F1));
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("latency", 39'(n), 39'd3);
        drain("drain_single");

        // back-to-back stream
        send(32'h4800_0000, val(1'b0, 8'h01, F1));
        send(32'h5000_0000, val(1'b0, 8'h02, F1));
        send(32'hC000_0000, val(1'b1, 8'h00, F1));
        send(32'h7FFF_FFFF, val(1'b0, 8'h78, F1));
        send(32'h0000_0001, val(1'b0, 8'h88, F1));
        send(32'h0000_0000, 39'h001);
        send(32'h8000_0000, 39'h002);
        send(32'h4400_0000, val(1'b0, 8'h00, 28'hC00_0000));
        send(32'hB800_0000, val(1'b1, 8'h01, F1));
        send(32'h2000_0000, val(1'b0, 8'hFC, F1));
        drain("drain_stream");

        // backpressure: only three fit while the output is stalled
        bp_in[0] = 32'h4800_0000; bp_exp[0] = val(1'b0, 8'h01, F1);
        bp_in[1] = 32'h5000_0000; bp_exp[1] = val(1'b0, 8'h02, F1);
        bp_in[2] = 32'h4000_0000; bp_exp[2] = val(1'b0, 8'h00, F1);
        bp_in[3] = 32'h7FFF_FFFF; bp_exp[3] = val(1'b0, 8'h78, F1);
        bp_in[4] = 32'h0000_0001; bp_exp[4] = val(1'b0, 8'h88, F1);
        pops0         = pops;
        bus.out_ready = 1'b0;
        idx           = 0;
        bus.in_data   = bp_in[0];
        bus.in_valid  = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(bp_exp[idx]);
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 5) bus.in_data = bp_in[idx];
        end
        check("bp_accepted", 39'(idx), 39'd3);
        check("bp_in_ready", 39'(bus.in_ready), 39'd0);
        check("bp_out_valid", 39'(bus.out_valid), 39'd1);
        held = bus.out_data;
        repeat (3) @(posedge clk);
        #1;
        check("bp_stable", bus.out_data, held);
        bus.out_ready = 1'b1;
        n = 0;
        while (idx < 5 && n < 50) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(bp_exp[idx]);
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 5) bus.in_data = bp_in[idx];
            n++;
        end
        bus.in_valid = 1'b0;
        drain("drain_bp");
        check("bp_delivered", 39'(pops - pops0), 39'd5);

        // reset with items in flight
        bus.out_ready = 1'b0;
        send(32'h4800_0000, val(1'b0, 8'h01, F1));
        send(32'h5000_0000, val(1'b0, 8'h02, F1));
        @(posedge clk);
        #1;
        check("pre_reset_valid", 39'(bus.out_valid), 39'd1);
        reset = 1'b1;
        #1;
        check("async_reset_valid", 39'(bus.out_valid), 39'd0);
        check("async_reset_data", bus.out_data, 39'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rereset", 39'(bus.in_ready), 39'd1);
        pops0 = pops;
        send(32'h5000_0000, val(1'b0, 8'h02, F1));
        drain("drain_after_reset");
        check("post_reset_count", 39'(pops - pops0), 39'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/posit_extract_stream_es2.md
Name: posit_extract_stream_es2

Overview:
- Pipelined decoder from a 32-bit posit (ES=2) to the serialized value format that the normalize blocks take as input: {sgn, scale, fraction, inf, zero}.
- It is the inverse of the normalize/encode path. It feeds the posit arithmetic units from memory or streams.
- Valid/ready handshake on both sides, three register stages, full per-stage backpressure.

Parameters:
- NBITS, 32, posit width (fixed for this block).
- ES, 2, exponent field width.
- SCALE_W, 8, signed scale width; range -120..120.
- FRAC_W, 28, fraction width: hidden bit plus 27 fraction bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  32  posit word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  39  serialized value: [38]=sgn, [37:30]=scale (two's complement), [29:2]=fraction, [1]=inf, [0]=zero.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.

Behaviour:
- Reset:
  - Clears all stage valid bits; out_valid=0 and out_data=0.
  - in_ready goes to 1 on the first edge after reset deasserts.
  - Reset mid-operation discards every in-flight item; nothing is replayed.
- Handshake:
  - A transfer occurs when valid&ready are both high at the rising clk edge.
  - out_data must hold stable while out_valid=1 and out_ready=0.
  - in_ready is combinational: in_ready = ~s1_valid | s1_adv.
  - Stage k advances when stage k is not full, or when stage k+1 advances.
  - Last stage advances on ~s3_valid | out_ready.
  - Bubbles collapse. Up to 3 items are held. Order is preserved.
- Latency: 3 cycles from accept to out_valid with out_ready held high. Throughput is 1 item per cycle.
- Stage 1 (classify and absolute value):
  - zero = (p==0); inf = (p==32'h8000_0000).
  - sgn = p[31] & ~inf & ~zero.
  - a = sgn ? -p : p, kept in 32 bits; only a[30:0] is used afterwards.
- Stage 2 (regime):
  - r0 = a[30].
  - k = length of the run of bits equal to r0, starting at a[30]; 1..31.
  - regime = r0 ? k-1 : -k.
  - rem = a[30:0] << (k+1), zero-filled. This drops the run and the terminating bit; when k=31 there is no terminating bit.
- Stage 3 (assemble):
  - exp = rem[30:29]. Exponent bits that fall outside the word read as 0.
  - scale = regime*4 + exp, computed signed in SCALE_W bits.
  - fraction = {1'b1, rem[28:2]}.
  - If inf or zero: sgn=0, scale=0, fraction=0, and only the flag is set.
- Boundaries:
  - maxpos 0x7FFFFFFF: k=31, regime=30, scale=+120.
  - minpos 0x00000001: k=30, regime=-30, exp=0, scale=-120.
  - A negative input is decoded as its two's complement.
  - inf and zero never both 1.
- Simultaneous input accept and output drain when all 3 stages are full: allowed. Everything shifts by one and in_ready stays 1.

Decomposition:
- Add to posit_defines:
  - POSIT_SERIALIZED_WIDTH_ES2 = 39.
  - value_es2 packed struct {sgn, scale[7:0], fraction[27:0], inf, zero}.
  - NaR constant 32'h8000_0000.
- One sub-module: posit_regime_count. Combinational leading-run counter on 31 bits; outputs k (5 bits) and the shifted remainder. It is instantiated in stage 2.

Test Plan:
- 0x40000000, out_ready=1 -> after 3 cycles: sgn=0, scale=0, fraction=0x8000000, inf=0, zero=0.
- 0x48000000 / 0x50000000 / 0xC0000000 back-to-back -> scale 1, 2, 0 in order; third result has sgn=1; all fractions 0x8000000.
- 0x7FFFFFFF and 0x00000001 -> scale=+120 (0x78) and -120 (0x88) respectively; fraction=0x8000000 for both.
- 0x00000000 and 0x80000000 -> out_data=0x001 (zero) and out_data=0x002 (inf).
- Backpressure: 5 items streamed with out_ready=0 -> exactly 3 accepted, then in_ready=0 and out_data stable. Raise out_ready -> all 5 delivered in order with no duplicates.
- Reset asserted with 2 items in flight -> out_valid=0 immediately (asynchronous). After release, no stale item appears and the next item decodes correctly.
